// File: rtl/c3po_packer.sv
// C-3PO transmit packer: gathers 32-byte narrow beats into 160-byte wide words,
// flags framing errors and holds one finished word under output backpressure.
module c3po_packer #(
    parameter int unsigned IN_BYTES_P = 32,
    parameter int unsigned BEATS_P    = 5
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_in_val,
    input  logic                            i_in_sop,
    input  logic                            i_in_eop,
    input  logic [7:0]                      i_in_vbc,
    input  logic [IN_BYTES_P*8-1:0]         i_in_data,
    output logic                            o_in_ready,
    output logic                            o_out_val,
    output logic                            o_out_sop,
    output logic                            o_out_eop,
    output logic [7:0]                      o_out_vbc,
    output logic [IN_BYTES_P*BEATS_P*8-1:0] o_out_data,
    input  logic                            i_out_ready,
    output logic                            o_idle,
    output logic                            o_err
);

    localparam int unsigned InW  = IN_BYTES_P * 8;
    localparam int unsigned OutW = IN_BYTES_P * BEATS_P * 8;
    localparam int unsigned CntW = (BEATS_P > 1) ? $clog2(BEATS_P) : 1;

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    state_e              r_state, w_state_nxt;
    logic [CntW-1:0]     r_cnt, w_cnt_nxt;
    logic                r_first, w_first_nxt;
    logic [OutW-1:0]     r_acc, w_acc_nxt;
    logic                r_out_val, r_out_sop, r_out_eop, r_err;
    logic [7:0]          r_out_vbc;
    logic [OutW-1:0]     r_out_data;

    logic                w_take, w_vbc_legal, w_vbc_err, w_load, w_err_nxt, w_word_sop;
    logic [7:0]          w_vbc_eff, w_word_vbc;
    logic [CntW-1:0]     w_slot;
    logic [InW-1:0]      w_beat;

    assign o_in_ready  = !r_out_val || i_out_ready;
    assign w_take      = i_in_val && o_in_ready;
    assign w_vbc_legal = (i_in_vbc != 8'd0) && (i_in_vbc <= 8'(IN_BYTES_P));
    // Only a legal final beat may be short; everything else counts as a full beat.
    assign w_vbc_eff   = (i_in_eop && w_vbc_legal) ? i_in_vbc : 8'(IN_BYTES_P);
    assign w_vbc_err   = !w_vbc_legal || (!i_in_eop && (i_in_vbc != 8'(IN_BYTES_P)));
    assign w_word_vbc  = 8'(IN_BYTES_P * 32'(w_slot)) + w_vbc_eff;

    always_comb begin
        w_beat = '0;
        for (int j = 0; j < IN_BYTES_P; j++) begin
            if (8'(j) < w_vbc_eff) begin
                w_beat[8*j +: 8] = i_in_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = r_first;
        w_acc_nxt   = r_acc;
        w_load      = 1'b0;
        w_err_nxt   = 1'b0;
        w_word_sop  = r_first;
        w_slot      = r_cnt;
        if (w_take) begin
            w_err_nxt = w_vbc_err;
            if (r_state == StIdle && !i_in_sop) begin
                w_err_nxt = 1'b1;
            end else begin
                // A sop restarts the packet, discarding any partial word in flight.
                if (i_in_sop) begin
                    w_slot     = '0;
                    w_word_sop = 1'b1;
                    if (r_state == StAcc) begin
                        w_err_nxt = 1'b1;
                    end
                end
                if (w_slot == '0) begin
                    w_acc_nxt = '0;
                end
                for (int s = 0; s < BEATS_P; s++) begin
                    if (CntW'(s) == w_slot) begin
                        w_acc_nxt[s*InW +: InW] = w_beat;
                    end
                end
                if (i_in_eop || w_slot == CntW'(BEATS_P - 1)) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_first_nxt = 1'b0;
                    w_state_nxt = i_in_eop ? StIdle : StAcc;
                end else begin
                    w_cnt_nxt   = w_slot + CntW'(1);
                    w_first_nxt = w_word_sop;
                    w_state_nxt = StAcc;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_acc      <= '0;
            r_err      <= 1'b0;
            r_out_val  <= 1'b0;
            r_out_sop  <= 1'b0;
            r_out_eop  <= 1'b0;
            r_out_vbc  <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= w_first_nxt;
            r_acc   <= w_acc_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_out_val  <= 1'b1;
                r_out_sop  <= w_word_sop;
                r_out_eop  <= i_in_eop;
                r_out_vbc  <= w_word_vbc;
                r_out_data <= w_acc_nxt;
            end else if (i_out_ready) begin
                r_out_val <= 1'b0;
            end
        end
    end

    assign o_out_val  = r_out_val;
    assign o_out_sop  = r_out_sop;
    assign o_out_eop  = r_out_eop;
    assign o_out_vbc  = r_out_vbc;
    assign o_out_data = r_out_data;
    assign o_err      = r_err;
    assign o_idle     = (r_state == StIdle) && !r_out_val;

endmodule

// File: tb/tb_c3po_packer.sv
// Bench for c3po_packer: directed framing/backpressure steps plus random packets,
// each wide word checked against a byte-queue model of the packet.
module tb_c3po_packer;

    logic          clk = 1'b0;
    logic          i_reset, i_in_val, i_in_sop, i_in_eop, i_out_ready;
    logic [7:0]    i_in_vbc;
    logic [255:0]  i_in_data;
    logic          o_in_ready, o_out_val, o_out_sop, o_out_eop, o_idle, o_err;
    logic [7:0]    o_out_vbc;
    logic [1279:0] o_out_data;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [7:0]    vbc;
        logic [1279:0] data;
    } word_t;

    word_t exp_q[$];
    word_t got_q[$];
    int    total = 0;
    int    bad = 0;
    int    err_cnt = 0;

    c3po_packer #(.IN_BYTES_P(32), .BEATS_P(5)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_in_val    (i_in_val),
        .i_in_sop    (i_in_sop),
        .i_in_eop    (i_in_eop),
        .i_in_vbc    (i_in_vbc),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_out_val   (o_out_val),
        .o_out_sop   (o_out_sop),
        .o_out_eop   (o_out_eop),
        .o_out_vbc   (o_out_vbc),
        .o_out_data  (o_out_data),
        .i_out_ready (i_out_ready),
        .o_idle      (o_idle),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!i_reset && o_out_val && i_out_ready)
            got_q.push_back('{o_out_sop, o_out_eop, o_out_vbc, o_out_data});
        if (!i_reset && o_err) err_cnt++;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [1279:0] obs, input logic [1279:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic sop, input logic eop, input logic [7:0] vbc,
                            input logic [1279:0] data);
        exp_q.push_back('{sop, eop, vbc, data});
    endtask

    // Presents one beat and holds it until the packer takes it.
    task automatic send_beat(input logic sop, input logic eop, input logic [7:0] vbc,
                             input logic [255:0] data, input bit rnd_bp);
        int waited = 0;
        i_in_val  = 1'b1;
        i_in_sop  = sop;
        i_in_eop  = eop;
        i_in_vbc  = vbc;
        i_in_data = data;
        forever begin
            if (rnd_bp) i_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (o_in_ready) break;
            waited++;
            if (waited > 100) begin
                total++;
                bad++;
                $error("FAIL beat_timeout in_ready=%0b expected=1", o_in_ready);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        i_in_val = 1'b0;
        i_in_sop = 1'b0;
        i_in_eop = 1'b0;
    endtask

    function automatic logic [255:0] rnd_beat();
        logic [255:0] d;
        for (int j = 0; j < 32; j++) d[8*j +: 8] = 8'($urandom);
        return d;
    endfunction

    // Model: packet is a byte string; wide words are consecutive 160-byte slices.
    task automatic send_packet(input int len, input bit incr, input bit rnd_bp);
        byte unsigned pkt[$];
        logic [1279:0] wd;
        logic [255:0]  bd;
        int nwords, nbeats, n;
        for (int i = 0; i < len; i++) pkt.push_back(incr ? 8'(i) : 8'($urandom));
        nwords = (len + 159) / 160;
        for (int w = 0; w < nwords; w++) begin
            n  = (len - 160 * w < 160) ? len - 160 * w : 160;
            wd = '0;
            for (int b = 0; b < n; b++) wd[8*b +: 8] = pkt[160*w + b];
            push_exp(w == 0, w == nwords - 1, 8'(n), wd);
        end
        nbeats = (len + 31) / 32;
        for (int b = 0; b < nbeats; b++) begin
            n  = (len - 32 * b < 32) ? len - 32 * b : 32;
            bd = rnd_beat();
            for (int j = 0; j < n; j++) bd[8*j +: 8] = pkt[32*b + j];
            send_beat(b == 0, b == nbeats - 1, 8'(n), bd, rnd_bp);
        end
    endtask

    task automatic check_words(input string tag);
        int n = 0;
        int m;
        i_out_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk32({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk32({tag, "_sop"}, 32'(got_q[i].sop), 32'(exp_q[i].sop));
            chk32({tag, "_eop"}, 32'(got_q[i].eop), 32'(exp_q[i].eop));
            chk32({tag, "_vbc"}, 32'(got_q[i].vbc), 32'(exp_q[i].vbc));
            chkw({tag, "_data"}, got_q[i].data, exp_q[i].data);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [255:0]  bx, by;
        logic [1279:0] wx;
        int e0;
        i_reset     = 1'b1;
        i_in_val    = 1'b0;
        i_in_sop    = 1'b0;
        i_in_eop    = 1'b0;
        i_in_vbc    = 8'd0;
        i_in_data   = '0;
        i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        chk32("rst_out_val", 32'(o_out_val), 32'd0);
        chk32("rst_out_vbc", 32'(o_out_vbc), 32'd0);
        chkw("rst_out_data", o_out_data, '0);
        chk32("rst_err", 32'(o_err), 32'd0);
        chk32("rst_idle", 32'(o_idle), 32'd1);
        chk32("rst_in_ready", 32'(o_in_ready), 32'd1);

        // Full 160-byte word with incrementing bytes, plus load latency.
        send_packet(160, 1'b1, 1'b0);
        chk32("t1_latency", 32'(o_out_val), 32'd1);
        check_words("t1");

        send_packet(40, 1'b0, 1'b0);
        check_words("t2");
        send_packet(200, 1'b0, 1'b0);
        check_words("t3");

        // Hold a finished word for 10 cycles with the next beat waiting.
        i_out_ready = 1'b0;
        send_packet(160, 1'b0, 1'b0);
        by = rnd_beat();
        push_exp(1'b1, 1'b1, 8'd32, {1024'b0, by});
        i_in_val  = 1'b1;
        i_in_sop  = 1'b1;
        i_in_eop  = 1'b1;
        i_in_vbc  = 8'd32;
        i_in_data = by;
        for (int c = 0; c < 10; c++) begin
            chk32("t4_hold_in_ready", 32'(o_in_ready), 32'd0);
            chk32("t4_hold_val", 32'(o_out_val), 32'd1);
            chk32("t4_hold_vbc", 32'(o_out_vbc), 32'(exp_q[0].vbc));
            chkw("t4_hold_data", o_out_data, exp_q[0].data);
            @(posedge clk);
            #1;
        end
        i_out_ready = 1'b1;
        #1;
        chk32("t4_release_in_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk);
        #1;
        i_in_val = 1'b0;
        check_words("t4");

        // sop mid-packet abandons X; only Y comes out.
        e0 = err_cnt;
        send_beat(1'b1, 1'b0, 8'd32, rnd_beat(), 1'b0);
        send_beat(1'b0, 1'b0, 8'd32, rnd_beat(), 1'b0);
        chk32("t5_busy_idle", 32'(o_idle), 32'd0);
        by = rnd_beat();
        push_exp(1'b1, 1'b1, 8'd16, {1152'b0, by[127:0]});
        send_beat(1'b1, 1'b1, 8'd16, by, 1'b0);
        check_words("t5y");
        chk32("t5_err_sop", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt;
        send_beat(1'b0, 1'b1, 8'd32, rnd_beat(), 1'b0);
        check_words("t5n");
        chk32("t5_err_nosop", 32'(err_cnt - e0), 32'd1);
        chk32("t5_idle", 32'(o_idle), 32'd1);

        // Short non-final beat counts as full; vbc=0 on the final beat counts as full.
        e0 = err_cnt;
        bx = rnd_beat();
        by = rnd_beat();
        wx = '0;
        wx[255:0]   = bx;
        wx[319:256] = by[63:0];
        push_exp(1'b1, 1'b1, 8'd40, wx);
        send_beat(1'b1, 1'b0, 8'd10, bx, 1'b0);
        send_beat(1'b0, 1'b1, 8'd8, by, 1'b0);
        check_words("t5v");
        chk32("t5_err_vbc", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt;
        by = rnd_beat();
        push_exp(1'b1, 1'b1, 8'd32, {1024'b0, by});
        send_beat(1'b1, 1'b1, 8'd0, by, 1'b0);
        check_words("t5z");
        chk32("t5_err_vbc0", 32'(err_cnt - e0), 32'd1);

        // Reset mid-packet drops the partial word.
        send_beat(1'b1, 1'b0, 8'd32, rnd_beat(), 1'b0);
        send_beat(1'b0, 1'b0, 8'd32, rnd_beat(), 1'b0);
        send_beat(1'b0, 1'b0, 8'd32, rnd_beat(), 1'b0);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        chk32("t6_out_val", 32'(o_out_val), 32'd0);
        chk32("t6_idle", 32'(o_idle), 32'd1);
        chk32("t6_err", 32'(o_err), 32'd0);
        send_packet(32, 1'b0, 1'b0);
        check_words("t6");

        for (int p = 0; p < 8; p++) send_packet(int'($urandom_range(1, 400)), 1'b0, 1'b1);
        check_words("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
